// File: rtl/risk_pkg.sv
// risk_pkg: shared definitions for the risk issue stage.
//   - risk function codes and field widths
//   - risk_cmd_t: packed 51-bit command (func, reg select, addr, strides)
//   - FSM state type and func classification helpers
package risk_pkg;

    localparam int RISK_FUNC_W   = 3;
    localparam int RISK_REG_W    = 5;
    localparam int RISK_ADDR_W   = 15;
    localparam int RISK_STRIDE_W = 14;

    localparam logic [RISK_FUNC_W-1:0] RISK_NOP    = 3'b000;
    localparam logic [RISK_FUNC_W-1:0] RISK_STORE  = 3'b001;
    localparam logic [RISK_FUNC_W-1:0] RISK_LOAD   = 3'b010;
    localparam logic [RISK_FUNC_W-1:0] RISK_MATMUL = 3'b011;
    localparam logic [RISK_FUNC_W-1:0] RISK_ADD    = 3'b100;

    typedef struct packed {
        logic [RISK_FUNC_W-1:0]   func;
        logic [RISK_REG_W-1:0]    regsel;
        logic [RISK_ADDR_W-1:0]   addr;
        logic [RISK_STRIDE_W-1:0] stride_x;
        logic [RISK_STRIDE_W-1:0] stride_y;
    } risk_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } risk_state_t;

    // Codes that produce real work for the risk unit (NOP excluded).
    function automatic logic is_issuable(input logic [RISK_FUNC_W-1:0] f);
        return (f >= RISK_STORE) && (f <= RISK_ADD);
    endfunction

    function automatic logic is_illegal(input logic [RISK_FUNC_W-1:0] f);
        return f > RISK_ADD;
    endfunction

endpackage

// File: rtl/risk_cmd_fifo.sv
// risk_cmd_fifo: synchronous FIFO of risk_cmd_t.
//   clk, resetn   : clock, synchronous active-low reset (empties the FIFO)
//   push, din     : write request and data (ignored when full)
//   pop, dout     : read request and head-of-queue data (ignored when empty)
//   full, empty   : occupancy flags
// Pointers carry one extra wrap bit; full when only the wrap bits differ.
module risk_cmd_fifo
    import risk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  risk_cmd_t din,
    input  logic      pop,
    output risk_cmd_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    risk_cmd_t   mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/risk_issue.sv
// risk_issue: issue stage in front of the risk matrix unit.
// Buffers core commands in a FIFO and presents each one on the risk_*
// outputs for exactly HOLD_CYCLES clocks; NOPs are dropped silently and
// illegal codes (101..111) are dropped with a one-cycle err_illegal pulse.
//   clk, resetn          : clock, synchronous active-low reset
//   in_valid/in_ready    : command handshake from the core
//   in_func..in_stride_y : command fields
//   risk_*               : registered command driven to the risk unit
//   busy                 : FIFO non-empty or a command is being held
//   err_illegal          : pulse, cycle after an illegal code was accepted
// Optional macro RISK_ISSUE_STATS_EN adds saturating counters
//   stat_issued (16b), stat_stall (16b), stat_illegal (8b).
module risk_issue
    import risk_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RISK_FUNC_W-1:0]   in_func,
    input  logic [RISK_REG_W-1:0]    in_reg,
    input  logic [RISK_ADDR_W-1:0]   in_addr,
    input  logic [RISK_STRIDE_W-1:0] in_stride_x,
    input  logic [RISK_STRIDE_W-1:0] in_stride_y,
    output logic [RISK_FUNC_W-1:0]   risk_func,
    output logic [RISK_REG_W-1:0]    risk_reg,
    output logic [RISK_ADDR_W-1:0]   risk_addr,
    output logic [RISK_STRIDE_W-1:0] risk_stride_x,
    output logic [RISK_STRIDE_W-1:0] risk_stride_y,
    output logic                     busy,
    output logic                     err_illegal
`ifdef RISK_ISSUE_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_stall,
    output logic [7:0]               stat_illegal
`endif
);

    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

    risk_cmd_t   in_cmd;
    risk_cmd_t   head;
    risk_cmd_t   out_q;
    risk_state_t state_q;
    risk_state_t state_d;
    logic [3:0]  cnt_q;
    logic        full;
    logic        empty;
    logic        accept;
    logic        push;
    logic        illegal;
    logic        pop;
    logic        go_idle;

    // Ready comes from registered occupancy only: a pop in the same cycle
    // does not open a slot, keeping ready free of any path through the FSM.
    assign in_ready = resetn && !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_issuable(in_func);
    assign illegal  = accept && is_illegal(in_func);

    always_comb begin
        in_cmd          = '0;
        in_cmd.func     = in_func;
        in_cmd.regsel   = in_reg;
        in_cmd.addr     = in_addr;
        in_cmd.stride_x = in_stride_x;
        in_cmd.stride_y = in_stride_y;
    end

    risk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (in_cmd),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Last hold cycle: chain the next command with no NOP gap.
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            err_illegal <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_illegal <= illegal;
            if (pop) begin
                out_q <= head;
                cnt_q <= HOLD_M1;
            end else if (go_idle) begin
                // Only func returns to NOP; operand fields keep last values.
                out_q.func <= RISK_NOP;
            end else if (state_q == ST_HOLD) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign risk_func     = out_q.func;
    assign risk_reg      = out_q.regsel;
    assign risk_addr     = out_q.addr;
    assign risk_stride_x = out_q.stride_x;
    assign risk_stride_y = out_q.stride_y;
    assign busy          = !empty || (state_q == ST_HOLD);

`ifdef RISK_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_issued  <= '0;
            stat_stall   <= '0;
            stat_illegal <= '0;
        end else begin
            if (pop && (stat_issued != '1))
                stat_issued <= stat_issued + 1'b1;
            if (in_valid && !in_ready && (stat_stall != '1))
                stat_stall <= stat_stall + 1'b1;
            if (illegal && (stat_illegal != '1))
                stat_illegal <= stat_illegal + 1'b1;
        end
    end
`endif

endmodule
